// File: rtl/ledcube_pkg.sv
// ---------------------------------------------------------------------------
// ledcube_pkg
// Shared constants and types for the LED panel feed path.
//   CMD_WRITE     : command byte that opens a write-pixels packet
//   CTRL_WR_RGB   : channel enables driven with every video-memory write
//   parserStateT  : states of the pixel packet parser
// ---------------------------------------------------------------------------
package ledcube_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [3:0] CTRL_WR_RGB = 4'b0111;

    typedef enum logic [2:0] {
        CMD  = 3'd0,
        ADH  = 3'd1,
        ADL  = 3'd2,
        R    = 3'd3,
        G    = 3'd4,
        B    = 3'd5,
        DROP = 3'd6
    } parserStateT;

endpackage

// File: rtl/pixel_loader.sv
// ---------------------------------------------------------------------------
// pixel_loader
// Parses a byte stream of pixel packets (command, big-endian start address,
// RGB triplets) and issues single-cycle writes on the panel driver's
// video-memory port.
// Ports:
//   ctrl_clk, ctrl_resetn : clock, synchronous active-low reset
//   in_valid/in_data/in_last/in_ready : byte stream in (never back-pressures)
//   ctrl_en/ctrl_wr/ctrl_addr/ctrl_wdat : registered write strobe out
//   pkt_done/pkt_err      : one-cycle packet completion / error pulses
// ---------------------------------------------------------------------------
module pixel_loader
    import ledcube_pkg::*;
#(
    parameter int CHAINED     = 3,
    parameter int INPUT_DEPTH = 6,
    parameter int MAX_ADDR    = CHAINED * 128 + 16
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_resetn,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        ctrl_en,
    output logic [3:0]  ctrl_wr,
    output logic [15:0] ctrl_addr,
    output logic [23:0] ctrl_wdat,
    output logic        pkt_done,
    output logic        pkt_err
);

    parserStateT            r_state;
    logic [15:0]            r_addr;
    logic [INPUT_DEPTH-1:0] r_red;
    logic [INPUT_DEPTH-1:0] r_green;
    logic                   r_inReady;
    logic                   r_ctrlEn;
    logic [3:0]             r_ctrlWr;
    logic [15:0]            r_ctrlAddr;
    logic [23:0]            r_ctrlWdat;
    logic                   r_pktDone;
    logic                   r_pktErr;

    logic                   w_accept;
    logic                   w_inRange;
    logic [23:0]            w_wdat;

    assign w_accept  = in_valid && r_inReady;
    assign w_inRange = ({16'd0, r_addr} <= 32'(MAX_ADDR));

    // Pixel word for the write issued on the B byte: red/green come from the
    // latched channels, blue straight from the incoming byte. Taking the top
    // INPUT_DEPTH bits of each byte is the same as shifting right by
    // 8-INPUT_DEPTH; unused upper bits of each byte lane stay zero.
    always_comb begin
        w_wdat                      = '0;
        w_wdat[16 +: INPUT_DEPTH]   = r_red;
        w_wdat[8  +: INPUT_DEPTH]   = r_green;
        w_wdat[0  +: INPUT_DEPTH]   = in_data[7 -: INPUT_DEPTH];
    end

    // Parser FSM and output register stage. Strobes and packet pulses default
    // low every cycle so they last exactly one cycle; address and data hold
    // their last written value between strobes.
    always_ff @(posedge ctrl_clk) begin
        if (!ctrl_resetn) begin
            r_state    <= CMD;
            r_addr     <= '0;
            r_red      <= '0;
            r_green    <= '0;
            r_inReady  <= 1'b0;
            r_ctrlEn   <= 1'b0;
            r_ctrlWr   <= '0;
            r_ctrlAddr <= '0;
            r_ctrlWdat <= '0;
            r_pktDone  <= 1'b0;
            r_pktErr   <= 1'b0;
        end else begin
            r_inReady <= 1'b1;
            r_ctrlEn  <= 1'b0;
            r_ctrlWr  <= '0;
            r_pktDone <= 1'b0;
            r_pktErr  <= 1'b0;

            if (w_accept) begin
                case (r_state)
                    CMD: begin
                        if (in_data == CMD_WRITE && !in_last) begin
                            r_state <= ADH;
                        end else if (in_last) begin
                            r_pktErr <= 1'b1;
                        end else begin
                            r_state <= DROP;
                        end
                    end
                    ADH: begin
                        r_addr[15:8] <= in_data;
                        if (in_last) begin
                            r_state  <= CMD;
                            r_pktErr <= 1'b1;
                        end else begin
                            r_state <= ADL;
                        end
                    end
                    ADL: begin
                        r_addr[7:0] <= in_data;
                        if (in_last) begin
                            r_state  <= CMD;
                            r_pktErr <= 1'b1;
                        end else begin
                            r_state <= R;
                        end
                    end
                    R: begin
                        r_red <= in_data[7 -: INPUT_DEPTH];
                        if (in_last) begin
                            r_state  <= CMD;
                            r_pktErr <= 1'b1;
                        end else begin
                            r_state <= G;
                        end
                    end
                    G: begin
                        r_green <= in_data[7 -: INPUT_DEPTH];
                        if (in_last) begin
                            r_state  <= CMD;
                            r_pktErr <= 1'b1;
                        end else begin
                            r_state <= B;
                        end
                    end
                    B: begin
                        // Out-of-range pixels are swallowed silently, but the
                        // address still advances so later pixels line up.
                        if (w_inRange) begin
                            r_ctrlEn   <= 1'b1;
                            r_ctrlWr   <= CTRL_WR_RGB;
                            r_ctrlAddr <= r_addr;
                            r_ctrlWdat <= w_wdat;
                        end
                        r_addr <= r_addr + 16'd1;
                        if (in_last) begin
                            r_state   <= CMD;
                            r_pktDone <= 1'b1;
                        end else begin
                            r_state <= R;
                        end
                    end
                    DROP: begin
                        // A bad command is reported once, when its packet ends.
                        if (in_last) begin
                            r_state  <= CMD;
                            r_pktErr <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= CMD;
                    end
                endcase
            end
        end
    end

    assign in_ready  = r_inReady;
    assign ctrl_en   = r_ctrlEn;
    assign ctrl_wr   = r_ctrlWr;
    assign ctrl_addr = r_ctrlAddr;
    assign ctrl_wdat = r_ctrlWdat;
    assign pkt_done  = r_pktDone;
    assign pkt_err   = r_pktErr;

endmodule

// File: tb/tb_pixel_loader.sv
// ---------------------------------------------------------------------------
// tb_pixel_loader
// Self-checking bench for pixel_loader. Expected writes are queued as each
// packet is driven and popped by a monitor whenever ctrl_en is seen.
// ---------------------------------------------------------------------------
module tb_pixel_loader;

    localparam int MAX_ADDR = 3 * 128 + 16;

    typedef struct {
        logic [15:0] addr;
        logic [23:0] wdat;
        logic        done;
    } expWriteT;

    logic        ctrl_clk;
    logic        ctrl_resetn;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        ctrl_en;
    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic        pkt_done;
    logic        pkt_err;

    expWriteT    expQ[$];
    logic [7:0]  txBytes[$];
    int          strobeCycles[$];
    int          checkCount;
    int          errorCount;
    int          doneCount;
    int          errPulseCount;
    int          cycleCount;

    pixel_loader dut (
        .ctrl_clk    (ctrl_clk),
        .ctrl_resetn (ctrl_resetn),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .ctrl_en     (ctrl_en),
        .ctrl_wr     (ctrl_wr),
        .ctrl_addr   (ctrl_addr),
        .ctrl_wdat   (ctrl_wdat),
        .pkt_done    (pkt_done),
        .pkt_err     (pkt_err)
    );

    // 10 ns clock
    initial begin
        ctrl_clk = 1'b0;
        forever #5 ctrl_clk = ~ctrl_clk;
    end

    // Free-running cycle count used to measure strobe spacing
    always @(posedge ctrl_clk) begin
        cycleCount <= cycleCount + 1;
    end

    // Counts one comparison and reports it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the edge
    // where the DUT updates them
    always @(negedge ctrl_clk) begin
        expWriteT e;
        if (ctrl_resetn) begin
            if (pkt_done) doneCount++;
            if (pkt_err)  errPulseCount++;
            if (ctrl_en) begin
                strobeCycles.push_back(cycleCount);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected strobe", {16'd0, ctrl_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ctrl_addr", {16'd0, ctrl_addr}, {16'd0, e.addr});
                    checkOutput("ctrl_wdat", {8'd0, ctrl_wdat}, {8'd0, e.wdat});
                    checkOutput("ctrl_wr", {28'd0, ctrl_wr}, 32'h7);
                    checkOutput("pkt_done with strobe", {31'd0, pkt_done}, {31'd0, e.done});
                end
            end else begin
                checkOutput("ctrl_wr idle", {28'd0, ctrl_wr}, 32'h0);
            end
        end
    end

    task automatic pushExp(input logic [15:0] addr, input logic [23:0] wdat,
                           input logic done);
        expWriteT e;
        e.addr = addr;
        e.wdat = wdat;
        e.done = done;
        expQ.push_back(e);
    endtask

    // Drives txBytes back-to-back, in_last on the final byte; leaves valid high
    task automatic applyStimulus();
        for (int i = 0; i < txBytes.size(); i++) begin
            @(negedge ctrl_clk);
            in_valid = 1'b1;
            in_data  = txBytes[i];
            in_last  = (i == txBytes.size() - 1);
        end
        txBytes.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ctrl_clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'h00;
        end
    endtask

    task automatic startTest();
        doneCount     = 0;
        errPulseCount = 0;
        strobeCycles.delete();
    endtask

    task automatic endTest(input string name, input int expDone, input int expErr);
        idle(4);
        checkOutput({name, " pending writes"}, expQ.size(), 0);
        checkOutput({name, " pkt_done count"}, doneCount, expDone);
        checkOutput({name, " pkt_err count"}, errPulseCount, expErr);
        expQ.delete();
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, " in_ready"}, {31'd0, in_ready}, 0);
        checkOutput({name, " ctrl_en"}, {31'd0, ctrl_en}, 0);
        checkOutput({name, " ctrl_wr"}, {28'd0, ctrl_wr}, 0);
        checkOutput({name, " ctrl_addr"}, {16'd0, ctrl_addr}, 0);
        checkOutput({name, " ctrl_wdat"}, {8'd0, ctrl_wdat}, 0);
        checkOutput({name, " pkt_done"}, {31'd0, pkt_done}, 0);
        checkOutput({name, " pkt_err"}, {31'd0, pkt_err}, 0);
    endtask

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        doneCount     = 0;
        errPulseCount = 0;
        cycleCount    = 0;
        ctrl_resetn   = 1'b0;
        in_valid      = 1'b0;
        in_data       = 8'h00;
        in_last       = 1'b0;

        // Power-on reset
        repeat (3) @(negedge ctrl_clk);
        checkResetOutputs("reset");
        ctrl_resetn = 1'b1;
        checkOutput("in_ready before first high edge", {31'd0, in_ready}, 0);
        @(negedge ctrl_clk);
        checkOutput("in_ready after reset", {31'd0, in_ready}, 1);

        // 1: single pixel
        startTest();
        pushExp(16'd5, 24'h3F2001, 1'b1);
        txBytes = '{8'h01, 8'h00, 8'h05, 8'hFF, 8'h80, 8'h04};
        applyStimulus();
        endTest("single pixel", 1, 0);

        // 2: two pixels, strobes three cycles apart
        startTest();
        pushExp(16'd0, 24'h3F0000, 1'b0);
        pushExp(16'd1, 24'h003F00, 1'b1);
        txBytes = '{8'h01, 8'h00, 8'h00, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hFC, 8'h00};
        applyStimulus();
        endTest("two pixels", 1, 0);
        checkOutput("two pixels strobe count", strobeCycles.size(), 2);
        if (strobeCycles.size() == 2)
            checkOutput("two pixels strobe spacing", strobeCycles[1] - strobeCycles[0], 3);

        // 3: start at MAX_ADDR, only the first pixel is in range
        startTest();
        pushExp(16'(MAX_ADDR), 24'h2A2E33, 1'b0);
        txBytes = '{8'h01, 8'h01, 8'h90,
                    8'hAA, 8'hBB, 8'hCC, 8'hAA, 8'hBB, 8'hCC, 8'hAA, 8'hBB, 8'hCC};
        applyStimulus();
        endTest("max addr", 1, 0);

        // Address counter wraps from 0xFFFF (out of range) to 0x0000
        startTest();
        pushExp(16'd0, 24'h101010, 1'b1);
        txBytes = '{8'h01, 8'hFF, 8'hFF, 8'h04, 8'h08, 8'h0C, 8'h40, 8'h40, 8'h40};
        applyStimulus();
        endTest("addr wrap", 1, 0);

        // 4: bad command dropped, next packet follows with no dead cycle
        startTest();
        txBytes = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        applyStimulus();
        pushExp(16'd0, 24'h040404, 1'b1);
        txBytes = '{8'h01, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10};
        applyStimulus();
        endTest("bad command", 1, 1);

        // 5: in_last on the G byte
        startTest();
        txBytes = '{8'h01, 8'h00, 8'h03, 8'h11, 8'h22};
        applyStimulus();
        endTest("last on G", 0, 1);

        // Header with no pixels, then a lone write command byte
        startTest();
        txBytes = '{8'h01, 8'h00, 8'h03};
        applyStimulus();
        txBytes = '{8'h01};
        applyStimulus();
        endTest("header only", 0, 2);

        // 6: reset after the first address byte, then a full packet
        startTest();
        txBytes = '{8'h01, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80};
        pushExp(16'd0, 24'h202020, 1'b1);
        applyStimulus();
        txBytes = '{8'h01, 8'h12};
        for (int i = 0; i < 2; i++) begin
            @(negedge ctrl_clk);
            in_valid = 1'b1;
            in_data  = txBytes[i];
            in_last  = 1'b0;
        end
        txBytes.delete();
        @(negedge ctrl_clk);
        in_valid    = 1'b0;
        ctrl_resetn = 1'b0;
        @(negedge ctrl_clk);
        checkResetOutputs("mid-packet reset");
        ctrl_resetn = 1'b1;
        @(negedge ctrl_clk);
        checkOutput("in_ready after mid-packet reset", {31'd0, in_ready}, 1);
        pushExp(16'd7, 24'h102030, 1'b1);
        txBytes = '{8'h01, 8'h00, 8'h07, 8'h40, 8'h80, 8'hC0};
        applyStimulus();
        endTest("after reset", 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
